// File: rtl/fpu_wb_scoreboard.sv
// Hazard scoreboard and write-back arbiter for the 32-entry FP register file.
// Stalls conflicting issues and round-robins the single write port between FPU and load results.
module fpu_wb_scoreboard #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue_valid_i,
    output logic              issue_ready_o,
    input  logic [4:0]        issue_rs1_i,
    input  logic [4:0]        issue_rs2_i,
    input  logic [4:0]        issue_rs3_i,
    input  logic [2:0]        issue_rs_used_i,
    input  logic [4:0]        issue_rd_i,
    input  logic              issue_rd_we_i,
    input  logic              fpu_wb_valid_i,
    output logic              fpu_wb_ready_o,
    input  logic [4:0]        fpu_wb_rd_i,
    input  logic [31:0]       fpu_wb_data_i,
    input  logic              ld_wb_valid_i,
    output logic              ld_wb_ready_o,
    input  logic [4:0]        ld_wb_rd_i,
    input  logic [31:0]       ld_wb_data_i,
    output logic              rf_we_o,
    output logic [4:0]        rf_rd_o,
    output logic [31:0]       rf_wdata_o,
    output logic              idle_o,
    output logic              wb_err_o
);

    logic [31:0]      r_busy;
    logic [CNT_W-1:0] r_pending;
    logic             r_last_grant;
    logic             r_rf_we;
    logic [4:0]       r_rf_rd;
    logic [31:0]      r_rf_wdata;
    logic             r_wb_err;

    logic             w_hazard;
    logic             w_issue_ready;
    logic             w_set;
    logic             w_grant_fpu;
    logic             w_grant_ld;
    logic             w_grant;
    logic [4:0]       w_wb_rd;
    logic [31:0]      w_wb_data;
    logic             w_wb_hit;
    logic             w_wb_miss;
    logic [31:0]      w_busy_nxt;
    logic [CNT_W-1:0] w_pending_nxt;

    // Issue hazard check; f0 is never marked busy so it never stalls.
    always_comb begin
        w_hazard = (issue_rs_used_i[0] && r_busy[issue_rs1_i])
                || (issue_rs_used_i[1] && r_busy[issue_rs2_i])
                || (issue_rs_used_i[2] && r_busy[issue_rs3_i])
                || (issue_rd_we_i && (issue_rd_i != 5'd0) && r_busy[issue_rd_i]);
        w_issue_ready = !reset && !w_hazard
                     && (!issue_rd_we_i || (issue_rd_i == 5'd0)
                         || (r_pending < CNT_W'(MAX_OUTSTANDING)));
        w_set = issue_valid_i && w_issue_ready && issue_rd_we_i && (issue_rd_i != 5'd0);
    end

    // Round-robin: on a tie the source that did not win last time is granted.
    always_comb begin
        w_grant_fpu = !reset && fpu_wb_valid_i && (!ld_wb_valid_i || r_last_grant);
        w_grant_ld  = !reset && ld_wb_valid_i && (!fpu_wb_valid_i || !r_last_grant);
        w_grant     = w_grant_fpu || w_grant_ld;
        w_wb_rd     = w_grant_ld ? ld_wb_rd_i : fpu_wb_rd_i;
        w_wb_data   = w_grant_ld ? ld_wb_data_i : fpu_wb_data_i;
        w_wb_hit    = w_grant && (w_wb_rd != 5'd0) && r_busy[w_wb_rd];
        w_wb_miss   = w_grant && (w_wb_rd != 5'd0) && !r_busy[w_wb_rd];
    end

    // Scoreboard update: commit clear and issue set can land together on different registers.
    always_comb begin
        w_busy_nxt    = r_busy;
        w_pending_nxt = r_pending;
        if (w_wb_hit) begin
            w_busy_nxt[w_wb_rd] = 1'b0;
        end
        if (w_set) begin
            w_busy_nxt[issue_rd_i] = 1'b1;
        end
        case ({w_set, w_wb_hit})
            2'b10:   w_pending_nxt = r_pending + CNT_W'(1);
            2'b01:   w_pending_nxt = r_pending - CNT_W'(1);
            default: w_pending_nxt = r_pending;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy       <= 32'd0;
            r_pending    <= '0;
            r_last_grant <= 1'b1;
            r_rf_we      <= 1'b0;
            r_rf_rd      <= 5'd0;
            r_rf_wdata   <= 32'd0;
            r_wb_err     <= 1'b0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_pending <= w_pending_nxt;
            r_rf_we   <= w_grant;
            if (w_grant) begin
                r_last_grant <= w_grant_ld;
                r_rf_rd      <= w_wb_rd;
                r_rf_wdata   <= w_wb_data;
            end
            if (w_wb_miss) begin
                r_wb_err <= 1'b1;
            end
        end
    end

    assign issue_ready_o  = w_issue_ready;
    assign fpu_wb_ready_o = w_grant_fpu;
    assign ld_wb_ready_o  = w_grant_ld;
    assign rf_we_o        = r_rf_we;
    assign rf_rd_o        = r_rf_rd;
    assign rf_wdata_o     = r_rf_wdata;
    assign idle_o         = (r_pending == '0) && !r_rf_we;
    assign wb_err_o       = r_wb_err;

endmodule

// File: tb/tb_fpu_wb_scoreboard.sv
// Scoreboard bench for fpu_wb_scoreboard: a reference model predicts handshakes and
// queues expected register-file writes, which an independent monitor pops and compares.
module tb_fpu_wb_scoreboard;

    localparam int unsigned MAXO = 4;

    logic        clock;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  rs1, rs2, rs3;
    logic [2:0]  rs_used;
    logic [4:0]  rd;
    logic        rd_we;
    logic        fpu_v, fpu_rdy;
    logic [4:0]  fpu_rd;
    logic [31:0] fpu_data;
    logic        ld_v, ld_rdy;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic        idle;
    logic        wb_err;

    fpu_wb_scoreboard #(.MAX_OUTSTANDING(MAXO)) dut (
        .clock(clock), .reset(reset),
        .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
        .issue_rs1_i(rs1), .issue_rs2_i(rs2), .issue_rs3_i(rs3),
        .issue_rs_used_i(rs_used), .issue_rd_i(rd), .issue_rd_we_i(rd_we),
        .fpu_wb_valid_i(fpu_v), .fpu_wb_ready_o(fpu_rdy),
        .fpu_wb_rd_i(fpu_rd), .fpu_wb_data_i(fpu_data),
        .ld_wb_valid_i(ld_v), .ld_wb_ready_o(ld_rdy),
        .ld_wb_rd_i(ld_rd), .ld_wb_data_i(ld_data),
        .rf_we_o(rf_we), .rf_rd_o(rf_rd), .rf_wdata_o(rf_wdata),
        .idle_o(idle), .wb_err_o(wb_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    bit  mon_en = 0;

    // Reference model state
    bit [31:0] m_busy;
    int        m_pend;
    bit        m_last;
    bit        m_we;
    bit [4:0]  m_rd;
    bit [31:0] m_data;
    bit        m_err;
    bit        g_fpu, g_ld;

    // DUT values sampled in the most recent cycle
    logic s_issue_rdy, s_fpu_rdy, s_ld_rdy, s_rf_we, s_idle, s_err;
    logic [31:0] s_rf_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = '0; m_pend = 0; m_last = 1'b1;
        m_we = 1'b0; m_rd = '0; m_data = '0; m_err = 1'b0;
    endtask

    // One clock: compare combinational handshakes at the falling edge, advance the model.
    task automatic cycle();
        bit hz, rdy, fire;
        @(negedge clock);
        hz = (rs_used[0] && m_busy[rs1]) || (rs_used[1] && m_busy[rs2])
          || (rs_used[2] && m_busy[rs3]) || (rd_we && rd != 5'd0 && m_busy[rd]);
        rdy   = !reset && !hz && (!rd_we || rd == 5'd0 || m_pend < int'(MAXO));
        g_fpu = !reset && fpu_v && (!ld_v || m_last);
        g_ld  = !reset && ld_v && (!fpu_v || !m_last);
        s_issue_rdy = issue_ready; s_fpu_rdy = fpu_rdy; s_ld_rdy = ld_rdy;
        s_rf_we = rf_we; s_rf_wdata = rf_wdata; s_idle = idle; s_err = wb_err;
        chk("issue_ready", 32'(issue_ready), 32'(rdy));
        chk("fpu_ready", 32'(fpu_rdy), 32'(g_fpu));
        chk("ld_ready", 32'(ld_rdy), 32'(g_ld));
        chk("idle", 32'(idle), 32'(m_pend == 0 && !m_we));
        chk("wb_err", 32'(wb_err), 32'(m_err));
        if (reset) begin
            model_reset();
        end else begin
            fire = issue_valid && rdy;
            m_we = g_fpu || g_ld;
            if (m_we) begin
                m_rd   = g_fpu ? fpu_rd : ld_rd;
                m_data = g_fpu ? fpu_data : ld_data;
                m_last = g_ld;
                if (m_rd != 5'd0) begin
                    if (m_busy[m_rd]) begin
                        m_busy[m_rd] = 1'b0;
                        m_pend--;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
            if (fire && rd_we && rd != 5'd0) begin
                m_busy[rd] = 1'b1;
                m_pend++;
            end
        end
        exp_q.push_back('{we: m_we, rd: m_rd, data: m_data});
        @(posedge clock);
        #1;
        mon_en = 1'b1;
    endtask

    // Monitor: every falling edge the register-file outputs must match the oldest expectation.
    always @(negedge clock) begin
        wb_t e;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL wb_queue: got empty queue expected an entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("rf_we", 32'(rf_we), 32'(e.we));
                chk("rf_rd", 32'(rf_rd), 32'(e.rd));
                chk("rf_wdata", rf_wdata, e.data);
            end
        end
    end

    task automatic idle_inputs();
        issue_valid = 0; rs1 = 0; rs2 = 0; rs3 = 0; rs_used = 0; rd = 0; rd_we = 0;
        fpu_v = 0; fpu_rd = 0; fpu_data = 0; ld_v = 0; ld_rd = 0; ld_data = 0;
    endtask

    task automatic issue_wr(input logic [4:0] r);
        issue_valid = 1; rs_used = 3'b000; rd = r; rd_we = 1;
    endtask

    // Write back every busy register through the FPU port, lowest index first.
    task automatic drain();
        int sel;
        idle_inputs();
        for (int n = 0; n < 40 && m_busy != 0; n++) begin
            sel = 0;
            for (int r = 31; r >= 1; r--) if (m_busy[r]) sel = r;
            fpu_v = 1; fpu_rd = 5'(sel); fpu_data = $urandom;
            cycle();
            fpu_v = 0;
        end
        cycle();
    endtask

    // Choose a busy register not already offered on the other port; occasionally f0.
    task automatic pick(input bit excl_v, input logic [4:0] excl, output bit ok, output logic [4:0] r);
        int cand[$];
        ok = 0; r = '0;
        if ($urandom_range(7, 0) == 0) begin
            ok = 1;
            return;
        end
        for (int i = 1; i < 32; i++)
            if (m_busy[i] && !(excl_v && excl == 5'(i))) cand.push_back(i);
        if (cand.size() != 0) begin
            ok = 1;
            r = 5'(cand[$urandom_range(cand.size() - 1, 0)]);
        end
    endtask

    initial begin
        int fq[$], lq[$];
        logic [3:0] hist;
        bit ok;
        logic [4:0] r;

        idle_inputs();
        reset = 1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        cycle();
        reset = 0;

        // Producer/dependent with write-back and same-cycle-after issue
        issue_wr(5'd3);
        cycle();
        issue_valid = 1; rs1 = 5'd3; rs_used = 3'b001; rd = 5'd4; rd_we = 1;
        fpu_v = 1; fpu_rd = 5'd3; fpu_data = 32'h40400000;
        cycle();
        chk("dep_stalled", 32'(s_issue_rdy), 32'd0);
        fpu_v = 0;
        cycle();
        chk("dep_issues_on_commit", 32'(s_issue_rdy), 32'd1);
        chk("commit_we", 32'(s_rf_we), 32'd1);
        chk("commit_data", s_rf_wdata, 32'h40400000);
        drain();

        // Outstanding limit
        for (int i = 1; i <= 4; i++) begin
            issue_wr(5'(i));
            cycle();
        end
        issue_wr(5'd5);
        ld_v = 1; ld_rd = 5'd1; ld_data = 32'h3f800000;
        cycle();
        chk("f5_limit_stall", 32'(s_issue_rdy), 32'd0);
        ld_v = 0;
        cycle();
        chk("f5_after_commit", 32'(s_issue_rdy), 32'd1);
        drain();

        // Round-robin under contention from a fresh reset
        reset = 1; cycle(); reset = 0;
        for (int i = 10; i <= 13; i++) begin
            issue_wr(5'(i));
            cycle();
        end
        issue_valid = 0;
        fq = '{10, 12}; lq = '{11, 13};
        fpu_data = $urandom; ld_data = $urandom;
        for (int k = 0; k < 4; k++) begin
            fpu_v = (fq.size() != 0); fpu_rd = (fq.size() != 0) ? 5'(fq[0]) : 5'd0;
            ld_v  = (lq.size() != 0); ld_rd  = (lq.size() != 0) ? 5'(lq[0]) : 5'd0;
            cycle();
            hist[k] = s_fpu_rdy;
            if (g_fpu) begin void'(fq.pop_front()); fpu_data = $urandom; end
            if (g_ld)  begin void'(lq.pop_front()); ld_data  = $urandom; end
        end
        chk("rr_order", 32'(hist), 32'b0101);
        drain();

        // Write-after-write stall
        issue_wr(5'd7);
        cycle();
        issue_wr(5'd7);
        fpu_v = 1; fpu_rd = 5'd7; fpu_data = 32'h12345678;
        cycle();
        chk("waw_stall", 32'(s_issue_rdy), 32'd0);
        fpu_v = 0;
        cycle();
        chk("waw_fire", 32'(s_issue_rdy), 32'd1);
        issue_valid = 1; rs1 = 5'd7; rs_used = 3'b001; rd_we = 0;
        cycle();
        chk("waw_rebusy", 32'(s_issue_rdy), 32'd0);
        drain();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            issue_valid = 1'($urandom);
            rs1 = 5'($urandom); rs2 = 5'($urandom); rs3 = 5'($urandom);
            rs_used = 3'($urandom);
            rd = ($urandom_range(9, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
            rd_we = ($urandom_range(3, 0) != 0);
            if (!fpu_v && $urandom_range(1, 0) == 1) begin
                pick(ld_v, ld_rd, ok, r);
                if (ok) begin fpu_v = 1; fpu_rd = r; fpu_data = $urandom; end
            end
            if (!ld_v && $urandom_range(1, 0) == 1) begin
                pick(fpu_v, fpu_rd, ok, r);
                if (ok) begin ld_v = 1; ld_rd = r; ld_data = $urandom; end
            end
            cycle();
            if (g_fpu) fpu_v = 0;
            if (g_ld)  ld_v = 0;
        end
        drain();

        // f0 destination is untracked
        issue_wr(5'd0);
        cycle();
        issue_valid = 0;
        cycle();
        chk("rd0_idle", 32'(s_idle), 32'd1);

        // Write-back to a non-busy register raises the sticky error
        fpu_v = 1; fpu_rd = 5'd9; fpu_data = 32'hdeadbeef;
        cycle();
        fpu_v = 0;
        cycle();
        chk("err_set", 32'(s_err), 32'd1);
        cycle();
        chk("err_sticky", 32'(s_err), 32'd1);
        chk("err_idle", 32'(s_idle), 32'd1);

        // Reset while work is in flight and a write is staged
        issue_wr(5'd20); cycle();
        issue_wr(5'd21); cycle();
        issue_valid = 0;
        fpu_v = 1; fpu_rd = 5'd20; fpu_data = 32'h0badf00d;
        cycle();
        fpu_v = 0;
        reset = 1;
        cycle();
        chk("pre_reset_we", 32'(s_rf_we), 32'd1);
        reset = 0;
        cycle();
        chk("post_reset_idle", 32'(s_idle), 32'd1);
        chk("post_reset_we", 32'(s_rf_we), 32'd0);
        chk("post_reset_err", 32'(s_err), 32'd0);
        issue_valid = 1; rs1 = 5'd21; rs_used = 3'b001; rd_we = 0;
        cycle();
        chk("post_reset_unbusy", 32'(s_issue_rdy), 32'd1);
        idle_inputs();
        cycle();

        @(negedge clock);
        #1;
        mon_en = 0;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_wb_scoreboard.md
# fpu_wb_scoreboard

Hazard scoreboard and write-back arbiter for the 32-entry FP register file (3 read ports, 1 write port, write on falling clock edge, writes to f0 discarded). It sits between the FP issue stage and the register file.

- It stalls issue of any instruction whose sources or destination are still pending.
- It shares the single write port between the FPU result path and the FP load path, using round-robin arbitration.
- It drives the register-file write controls from registers.

## Interface
Parameters:
- MAX_OUTSTANDING, default 4: maximum in-flight register-writing instructions (1..31).
- CNT_W, default $clog2(MAX_OUTSTANDING+1): width of the pending counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- issue_valid_i  in  1  an instruction is presented for issue.
- issue_ready_o  out  1  the instruction may issue; combinational.
- issue_rs1_i, issue_rs2_i, issue_rs3_i  in  5 each  source register indices.
- issue_rs_used_i  in  3  per-source use mask; bit0 = rs1, bit1 = rs2, bit2 = rs3.
- issue_rd_i  in  5  destination register index.
- issue_rd_we_i  in  1  the instruction writes rd.
- fpu_wb_valid_i  in  1  an FPU result is offered.
- fpu_wb_ready_o  out  1  FPU result accepted this cycle.
- fpu_wb_rd_i  in  5  FPU result destination index.
- fpu_wb_data_i  in  32  FPU result data.
- ld_wb_valid_i  in  1  an FP load result is offered.
- ld_wb_ready_o  out  1  load result accepted this cycle.
- ld_wb_rd_i  in  5  load result destination index.
- ld_wb_data_i  in  32  load result data.
- rf_we_o  out  1  register file write enable.
- rf_rd_o  out  5  register file write index.
- rf_wdata_o  out  32  register file write data.
- idle_o  out  1  pending count is 0 and rf_we_o is 0.
- wb_err_o  out  1  sticky: a write-back was granted to a register that was not busy.

## Operation
State:
- busy[31:0]: one bit per register.
- pending: CNT_W-bit counter of in-flight writing instructions.
- last_grant: 0 = FPU granted last, 1 = load granted last.
- Write-back output registers and wb_err_o.

Issue:
- Hazard: any used source rsN with busy[rsN]=1, OR issue_rd_we_i=1 with rd!=0 and busy[rd]=1.
- issue_ready_o = no hazard AND (issue_rd_we_i=0 OR rd=0 OR pending<MAX_OUTSTANDING).
- Fire = issue_valid_i & issue_ready_o.
- On fire with issue_rd_we_i=1 and rd!=0: set busy[rd] and increment pending.
- rd=0 is never tracked and never counted, because its write is discarded.

Write-back arbitration:
- Only one source valid: that source is granted.
- Both valid: the source not equal to last_grant is granted.
- Grant sets that source's ready for one cycle and updates last_grant.
- A source that is not granted holds valid, rd and data stable until granted.
- A source offering rd=0 is granted and consumed normally; the write is issued but busy and pending are not touched.

Commit, at the edge after a grant:
- rf_we_o=1; rf_rd_o and rf_wdata_o load from the granted source.
- busy[rd] clears and pending decrements.
- If busy[rd] was 0 (rd!=0), wb_err_o sets; pending does not decrement (it saturates at 0).
- No grant in a cycle: rf_we_o=0 the next cycle; rf_rd_o and rf_wdata_o hold their values.

Simultaneous events:
- Issue fire and write-back commit in the same cycle: set and clear apply together. They never target the same register, because issue is blocked while busy[rd]=1.
- pending changes by +1, -1, or net 0 when both occur.

## Timing
- Reset values: busy=0, pending=0, last_grant=1 (FPU wins the first tie), rf_we_o=0, rf_rd_o=0, rf_wdata_o=0, wb_err_o=0, idle_o=1. Both ready outputs are 0 while reset is high.
- Reset mid-operation discards all busy bits and any write staged in the output registers. rf_we_o is low in the cycle after reset.
- Write-back latency: a grant in cycle N gives rf_we_o high in cycle N+1. The register file writes on the falling edge within N+1.
- busy[rd] is 0 from cycle N+1. A dependent instruction may issue in N+1; its combinational register-file read after the falling edge returns the new value.
- Issue-to-ready dependency: the earliest a dependent can issue is the cycle after its producer's write-back commit.
- Sustained throughput: one write-back per cycle. Under continuous contention, grants alternate between the two sources.

## Test plan
- Reset, then issue rd=3 with rd_we=1 -> busy[3]=1, pending=1. A dependent with rs1=3 sees issue_ready_o=0. FPU write-back rd=3, data 0x40400000, granted in cycle N -> rf_we_o=1, rf_rd_o=3, rf_wdata_o=0x40400000 in N+1; the dependent issues in N+1.
- Issue to f1..f4 with MAX_OUTSTANDING=4 -> pending=4. Issue to f5 -> issue_ready_o=0. One write-back commits -> the f5 issue proceeds the same cycle the commit lands.
- FPU and load both valid every cycle for 4 cycles -> grants go FPU, load, FPU, load; the loser's ready stays 0 with its data held.
- WAW: busy[7]=1 and an issue with rd=7 -> stall. Commit of f7 -> issue fires the next cycle and busy[7] is set again.
- Write-back to non-busy f9 -> wb_err_o=1 and stays 1; pending unchanged. Issue to rd=0 -> pending and busy unchanged.
- Assert reset with pending=2 and rf_we_o=1 -> next cycle pending=0, busy=0, rf_we_o=0, idle_o=1.
